// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multiply/divide sequencer holding HI/LO with fixed-latency commit
module md_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [1:0]  mt_i,
  input  logic [31:0] wdata_i,
  input  logic        d_md_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] MUL_CNT = MUL_LAT[3:0];
  localparam logic [3:0] DIV_CNT = DIV_LAT[3:0];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [3:0]         lat_sel;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        div_b;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic [31:0]        res_hi, res_lo;
  logic               res_wr;

  // Arithmetic on the latched operands; the divisor is forced nonzero so the
  // divider never sees zero, and a zero divisor suppresses the commit instead.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    div_b  = (b_q == 32'd0) ? 32'd1 : b_q;
    quot_s = $signed(a_q) / $signed(div_b);
    rem_s  = $signed(a_q) % $signed(div_b);
    quot_u = a_q / div_b;
    rem_u  = a_q % div_b;
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b1;
    case (op_q)
      2'b00: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      2'b01: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      2'b10: begin
        res_hi = rem_s;
        res_lo = quot_s;
        res_wr = (b_q != 32'd0);
      end
      default: begin
        res_hi = rem_u;
        res_lo = quot_u;
        res_wr = (b_q != 32'd0);
      end
    endcase
  end

  // Next-state logic: issue/mt handling in IDLE, countdown and commit in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    lat_sel = op_i[1] ? DIV_CNT : MUL_CNT;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
          cnt_d   = lat_sel;
          state_d = S_BUSY;
          // done_o is registered, so a one-cycle latency raises it at issue.
          done_d  = (lat_sel == 4'd1);
        end else if (mt_i == 2'b01) begin
          hi_d = wdata_i;
        end else if (mt_i == 2'b10) begin
          lo_d = wdata_i;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // Raise done one edge early so it is high in the final busy cycle.
        if (cnt_q == 4'd2) begin
          done_d = 1'b1;
        end
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          if (res_wr) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset that also aborts any operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 2'b00;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy_o  = (state_q == S_BUSY);
  assign stall_o = d_md_i & (busy_o | start_i);
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - directed self-checking bench for md_ctrl
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [1:0]  mt_i;
  logic [31:0] wdata_i;
  logic        d_md_i;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;

  md_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .mt_i    (mt_i),
    .wdata_i (wdata_i),
    .d_md_i  (d_md_i),
    .busy_o  (busy_o),
    .stall_o (stall_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and step through its busy window. rep > 0 re-pulses start_i
  // with a different op in that busy cycle; it must be ignored.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic dmd,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] new_hi, input logic [31:0] new_lo, input int rep);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    d_md_i  = dmd;
    #1;
    chk({tag, " stall_start"}, stall_o, dmd);
    tick();
    start_i = 1'b0;
    a_i     = 32'd0;
    b_i     = 32'd0;
    for (int i = 1; i <= lat; i++) begin
      if (i == rep) begin
        start_i = 1'b1;
        op_i    = 2'b01;
        a_i     = 32'd3;
        b_i     = 32'd3;
      end
      #1;
      chk($sformatf("%s busy_c%0d", tag, i), busy_o, 1'b1);
      chk($sformatf("%s done_c%0d", tag, i), done_o, (i == lat));
      chk($sformatf("%s stall_c%0d", tag, i), stall_o, dmd);
      chk($sformatf("%s hilo_c%0d", tag, i), {hi_o, lo_o}, {old_hi, old_lo});
      tick();
      start_i = 1'b0;
    end
    d_md_i = dmd;
    #1;
    chk({tag, " busy_after"}, busy_o, 1'b0);
    chk({tag, " done_after"}, done_o, 1'b0);
    chk({tag, " stall_idle"}, stall_o, 1'b0);
    chk({tag, " hi"}, hi_o, new_hi);
    chk({tag, " lo"}, lo_o, new_lo);
  endtask

  initial begin
    int dones;
    reset   = 1'b0;
    start_i = 1'b0;
    op_i    = 2'b00;
    a_i     = 32'd0;
    b_i     = 32'd0;
    mt_i    = 2'b00;
    wdata_i = 32'd0;
    d_md_i  = 1'b0;
    tick();
    tick();
    chk("rst busy", busy_o, 1'b0);
    chk("rst done", done_o, 1'b0);
    chk("rst hi", hi_o, 32'd0);
    chk("rst lo", lo_o, 32'd0);
    d_md_i = 1'b1;
    #1;
    chk("rst stall_dmd_only", stall_o, 1'b0);
    start_i = 1'b1;
    #1;
    chk("rst stall_dmd_start", stall_o, 1'b1);
    start_i = 1'b0;
    d_md_i  = 1'b0;
    reset   = 1'b1;
    tick();

    // mult -3 * 5 = -15, operands cleared after issue
    run_op("mult", 2'b00, 32'hFFFFFFFD, 32'd5, 5, 1'b1,
           32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    // back-to-back divu 100/7 with an ignored mid-busy restart
    run_op("divu", 2'b11, 32'd100, 32'd7, 10, 1'b0,
           32'hFFFFFFFF, 32'hFFFFFFF1, 32'd2, 32'd14, 3);
    // div -7 / 2 = -3 rem -1
    run_op("div", 2'b10, 32'hFFFFFFF9, 32'd2, 10, 1'b1,
           32'd2, 32'd14, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);

    // mthi then mtlo on consecutive cycles
    mt_i    = 2'b01;
    wdata_i = 32'hDEADBEEF;
    tick();
    chk("mthi hi", hi_o, 32'hDEADBEEF);
    chk("mthi lo", lo_o, 32'hFFFFFFFD);
    mt_i    = 2'b10;
    wdata_i = 32'h12345678;
    tick();
    chk("mtlo hi", hi_o, 32'hDEADBEEF);
    chk("mtlo lo", lo_o, 32'h12345678);
    chk("mtlo busy", busy_o, 1'b0);
    chk("mtlo done", done_o, 1'b0);

    // preload and divide by zero
    mt_i    = 2'b01;
    wdata_i = 32'h11;
    tick();
    mt_i    = 2'b10;
    wdata_i = 32'h22;
    tick();
    mt_i = 2'b00;
    run_op("div0", 2'b10, 32'd5, 32'd0, 10, 1'b1,
           32'h11, 32'h22, 32'h11, 32'h22, 0);

    // start together with mthi: mt dropped; mtlo during busy ignored
    start_i = 1'b1;
    op_i    = 2'b00;
    a_i     = 32'd2;
    b_i     = 32'd3;
    mt_i    = 2'b01;
    wdata_i = 32'hAAAA;
    tick();
    start_i = 1'b0;
    chk("startmt hi", hi_o, 32'h11);
    chk("startmt busy", busy_o, 1'b1);
    mt_i    = 2'b10;
    wdata_i = 32'hBBBB;
    tick();
    mt_i = 2'b00;
    chk("busymt lo", lo_o, 32'h22);
    tick();
    tick();
    tick();
    chk("startmt done", done_o, 1'b1);
    tick();
    chk("startmt res_hi", hi_o, 32'd0);
    chk("startmt res_lo", lo_o, 32'd6);

    // reset abort in the third busy cycle of multu
    start_i = 1'b1;
    op_i    = 2'b01;
    a_i     = 32'hFFFFFFFF;
    b_i     = 32'd2;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    chk("abort busy_c3", busy_o, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort busy", busy_o, 1'b0);
    chk("abort done", done_o, 1'b0);
    chk("abort hi", hi_o, 32'd0);
    chk("abort lo", lo_o, 32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_o === 1'b1) dones++;
    end
    chk("abort no_done", dones, 0);
    chk("abort no_commit", {hi_o, lo_o}, 64'd0);
    chk("abort idle", busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
